uart_rx_deframer: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_deframer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the sample indices at which the bit centres are taken.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_STOP  = 3'd3;
    localparam state_t ST_BREAK = 3'd4;

    localparam int OVERSAMPLE = 16;

    // Start bit is judged half a bit in; every later bit a full bit after the previous.
    localparam logic [3:0] MID_START = 4'd7;
    localparam logic [3:0] MID_BIT   = 4'd15;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle os_tick every clk_div fast_clk cycles,
// restartable with a synchronous clear so ticks align to a detected start edge.
module uart_baud_tick #(
    parameter int clk_div = 27
) (
    input  logic fast_clk,
    input  logic nreset,
    input  logic clear,
    output logic os_tick
);

    localparam int CW = (clk_div > 1) ? $clog2(clk_div) : 1;

    logic [CW-1:0] cnt_reg;

    assign os_tick = (cnt_reg == CW'(clk_div - 1));

    always_ff @(posedge fast_clk or negedge nreset) begin
        if (!nreset) begin
            cnt_reg <= '0;
        end else if (clear || os_tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x oversampled, single centre sample per bit,
// start/stop checking, one-cycle strobes for good byte, framing error and overrun.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int data_bits = 8,
    parameter int clk_div   = 27
) (
    input  logic                 fast_clk,
    input  logic                 nreset,
    input  logic                 rx_in,
    input  logic                 fifo_full,
    output logic [data_bits-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (data_bits > 1) ? $clog2(data_bits) : 1;

    logic                 sync1_reg, sync2_reg, rx;
    state_t               state_reg, state_next;
    logic [SW-1:0]        sample_reg, sample_next;
    logic [BW-1:0]        bit_reg, bit_next;
    logic [data_bits-1:0] shift_reg, shift_next;
    logic [data_bits-1:0] data_reg, data_next;
    logic                 valid_reg, valid_next;
    logic                 ferr_reg, ferr_next;
    logic                 ovr_reg, ovr_next;
    logic                 tick_clear, os_tick;
    logic                 at_mid_start, at_mid_bit, at_last_bit;

    uart_baud_tick #(.clk_div(clk_div)) u_tick (
        .fast_clk (fast_clk),
        .nreset   (nreset),
        .clear    (tick_clear),
        .os_tick  (os_tick)
    );

    assign rx           = sync2_reg;
    assign at_mid_start = os_tick && (sample_reg == MID_START);
    assign at_mid_bit   = os_tick && (sample_reg == MID_BIT);
    assign at_last_bit  = (bit_reg == BW'(data_bits - 1));

    // Synchronizer flops reset high so a reset can never look like a start edge.
    always_ff @(posedge fast_clk or negedge nreset) begin
        if (!nreset) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            state_reg  <= ST_IDLE;
            sample_reg <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            ferr_reg   <= 1'b0;
            ovr_reg    <= 1'b0;
        end else begin
            sync1_reg  <= rx_in;
            sync2_reg  <= sync1_reg;
            state_reg  <= state_next;
            sample_reg <= sample_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            data_reg   <= data_next;
            valid_reg  <= valid_next;
            ferr_reg   <= ferr_next;
            ovr_reg    <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!rx) state_next = ST_START;
            ST_START: if (at_mid_start) state_next = rx ? ST_IDLE : ST_DATA;
            ST_DATA:  if (at_mid_bit && at_last_bit) state_next = ST_STOP;
            ST_STOP:  if (at_mid_bit) state_next = rx ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tick_clear  = 1'b0;
        sample_next = sample_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        data_next   = data_reg;
        valid_next  = 1'b0;
        ferr_next   = 1'b0;
        ovr_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!rx) begin
                    tick_clear  = 1'b1;
                    sample_next = '0;
                    bit_next    = '0;
                end
            end
            ST_START: begin
                if (at_mid_start) begin
                    sample_next = '0;
                end else if (os_tick) begin
                    sample_next = sample_reg + 1'b1;
                end
            end
            ST_DATA: begin
                // Sample counter wraps 15 -> 0, so each bit centre is 16 ticks after the last.
                if (os_tick) begin
                    sample_next = sample_reg + 1'b1;
                end
                if (at_mid_bit) begin
                    shift_next = {rx, shift_reg[data_bits-1:1]};
                    bit_next   = bit_reg + 1'b1;
                end
            end
            ST_STOP: begin
                if (os_tick) begin
                    sample_next = sample_reg + 1'b1;
                end
                if (at_mid_bit) begin
                    if (!rx) begin
                        ferr_next = 1'b1;
                    end else if (fifo_full) begin
                        ovr_next = 1'b1;
                    end else begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rx_data   = data_reg;
    assign rx_valid  = valid_reg;
    assign frame_err = ferr_reg;
    assign overrun   = ovr_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
